// File: rtl/rv32_commit_checker.sv
// In-order retire-stream checker: compares each commit against a preloaded expected trace
// and reports a registered pass/fail verdict, first-mismatch record and no-progress timeout.
module rv32_commit_checker #(
   parameter int unsigned TRACE_DEPTH    = 64,
   parameter int unsigned ADDR_WIDTH     = 6,
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  enable_i,
   input  logic                  trace_write_enable_i,
   input  logic [ADDR_WIDTH-1:0] trace_write_address_i,
   input  logic [68:0]           trace_write_data_i,
   input  logic [ADDR_WIDTH:0]   trace_length_i,
   input  logic                  commit_valid_i,
   input  logic [31:0]           commit_pc_i,
   input  logic [4:0]            commit_rd_i,
   input  logic [31:0]           commit_rd_value_i,
   output logic                  running_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  fail_o,
   output logic                  timeout_o,
   output logic [ADDR_WIDTH:0]   commit_count_o,
   output logic [31:0]           mismatch_pc_o,
   output logic [31:0]           mismatch_rd_value_o
);

   localparam int unsigned LW = ADDR_WIDTH + 1;
   localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PASS = 2'd2;
   localparam logic [1:0] ST_FAIL = 2'd3;

   logic [68:0]           trace_mem [TRACE_DEPTH];

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [LW-1:0]         len_q, len_d;
   logic [IW-1:0]         idle_q, idle_d;
   logic [LW-1:0]         count_q, count_d;
   logic [31:0]           mpc_q, mpc_d;
   logic [31:0]           mval_q, mval_d;
   logic                  tmo_q, tmo_d;
   logic                  running_q, done_q, pass_q, fail_q;

   logic [68:0]           exp_c;
   logic                  match_c;
   logic                  last_c;
   logic [IW-1:0]         idle_inc_c;

   // Expected-trace storage; deliberately not reset so a rerun can reuse the loaded trace.
   always_ff @(posedge clock_i) begin
      if (state_q == ST_IDLE && trace_write_enable_i)
         trace_mem[trace_write_address_i] <= trace_write_data_i;
   end

   assign exp_c      = trace_mem[idx_q];
   // Writes to x0 are architecturally discarded, so its value never participates.
   assign match_c    = (commit_pc_i == exp_c[68:37]) && (commit_rd_i == exp_c[36:32]) &&
                       ((commit_rd_i == 5'd0) || (commit_rd_value_i == exp_c[31:0]));
   assign last_c     = ({1'b0, idx_q} == (len_q - LW'(1)));
   assign idle_inc_c = idle_q + IW'(1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      idle_d  = idle_q;
      count_d = count_q;
      mpc_d   = mpc_q;
      mval_d  = mval_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (enable_i && trace_length_i != '0 && trace_length_i <= LW'(TRACE_DEPTH)) begin
               state_d = ST_RUN;
               len_d   = trace_length_i;
               idx_d   = '0;
               idle_d  = '0;
               count_d = '0;
            end
         end
         ST_RUN: begin
            if (enable_i) begin
               if (commit_valid_i) begin
                  if (match_c) begin
                     idx_d   = idx_q + ADDR_WIDTH'(1);
                     count_d = count_q + LW'(1);
                     idle_d  = '0;
                     if (last_c) state_d = ST_PASS;
                  end else begin
                     state_d = ST_FAIL;
                     mpc_d   = commit_pc_i;
                     mval_d  = commit_rd_value_i;
                  end
               end else begin
                  idle_d = idle_inc_c;
                  if (idle_inc_c == IW'(TIMEOUT_CYCLES)) begin
                     state_d = ST_FAIL;
                     tmo_d   = 1'b1;
                     mpc_d   = '0;
                     mval_d  = '0;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         idle_q    <= '0;
         count_q   <= '0;
         mpc_q     <= '0;
         mval_q    <= '0;
         tmo_q     <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         idle_q    <= idle_d;
         count_q   <= count_d;
         mpc_q     <= mpc_d;
         mval_q    <= mval_d;
         tmo_q     <= tmo_d;
         running_q <= (state_d == ST_RUN);
         done_q    <= (state_d == ST_PASS) || (state_d == ST_FAIL);
         pass_q    <= (state_d == ST_PASS);
         fail_q    <= (state_d == ST_FAIL);
      end
   end

   assign running_o           = running_q;
   assign done_o              = done_q;
   assign pass_o              = pass_q;
   assign fail_o              = fail_q;
   assign timeout_o           = tmo_q;
   assign commit_count_o      = count_q;
   assign mismatch_pc_o       = mpc_q;
   assign mismatch_rd_value_o = mval_q;

endmodule

// File: tb/tb_rv32_commit_checker.sv
// Directed bench for rv32_commit_checker: pass, mismatch, x0, timeout, reset and length cases.
module tb_rv32_commit_checker;

   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          twe = 1'b0;
   logic [AW-1:0] twa = '0;
   logic [68:0]   twd = '0;
   logic [AW:0]   tlen = '0;
   logic          cv = 1'b0;
   logic [31:0]   cpc = '0;
   logic [4:0]    crd = '0;
   logic [31:0]   cval = '0;
   logic          running, done, pass, fail, timeout;
   logic [AW:0]   count;
   logic [31:0]   mpc, mval;

   int vec = 0;
   int err = 0;

   rv32_commit_checker #(.TRACE_DEPTH(64), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100)) dut (
      .clock_i(clk), .reset_i(rst), .enable_i(en),
      .trace_write_enable_i(twe), .trace_write_address_i(twa), .trace_write_data_i(twd),
      .trace_length_i(tlen), .commit_valid_i(cv), .commit_pc_i(cpc), .commit_rd_i(crd),
      .commit_rd_value_i(cval), .running_o(running), .done_o(done), .pass_o(pass),
      .fail_o(fail), .timeout_o(timeout), .commit_count_o(count),
      .mismatch_pc_o(mpc), .mismatch_rd_value_o(mval)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; inputs and samples sit 1ns after it.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      en = 1'b0; cv = 1'b0; twe = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] v);
      twe = 1'b1; twa = a; twd = {pc, rd, v};
      step();
      twe = 1'b0;
   endtask

   task automatic load_basic();
      load(6'd0, 32'h0, 5'd1, 32'd5);
      load(6'd1, 32'h4, 5'd2, 32'd7);
      load(6'd2, 32'h8, 5'd3, 32'd12);
   endtask

   task automatic start(input logic [AW:0] l);
      tlen = l; en = 1'b1;
      step();
   endtask

   task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] v);
      cv = 1'b1; cpc = pc; crd = rd; cval = v;
      step();
      cv = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      vec++; if ({running, done, pass, fail, timeout} !== 5'b0) begin err++;
         $display("FAIL reset_flags got %b exp 00000", {running, done, pass, fail, timeout}); end
      vec++; if (count !== '0) begin err++; $display("FAIL reset_count got %0d exp 0", count); end
      vec++; if ({mpc, mval} !== 64'h0) begin err++;
         $display("FAIL reset_mismatch got %h/%h exp 0/0", mpc, mval); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_pass();
      do_reset();
      load_basic();
      start(7'd3);
      vec++; if (running !== 1'b1) begin err++; $display("FAIL pass_running got %b exp 1", running); end
      cv = 1'b1; cpc = 32'h0; crd = 5'd1; cval = 32'd5;
      step();
      vec++; if (count !== 7'd1) begin err++; $display("FAIL pass_count1 got %0d exp 1", count); end
      cpc = 32'h4; crd = 5'd2; cval = 32'd7;
      step();
      cpc = 32'h8; crd = 5'd3; cval = 32'd12;
      step();
      cv = 1'b0;
      vec++; if ({pass, done, fail, running} !== 4'b1100) begin err++;
         $display("FAIL pass_flags got %b exp 1100", {pass, done, fail, running}); end
      vec++; if (count !== 7'd3) begin err++; $display("FAIL pass_count got %0d exp 3", count); end
   endtask

   task automatic test_mismatch();
      do_reset();
      load_basic();
      start(7'd3);
      commit(32'h0, 5'd1, 32'd5);
      commit(32'h4, 5'd2, 32'd8);
      vec++; if ({fail, done, pass, timeout} !== 4'b1100) begin err++;
         $display("FAIL mm_flags got %b exp 1100", {fail, done, pass, timeout}); end
      vec++; if (mpc !== 32'h4) begin err++; $display("FAIL mm_pc got %h exp 4", mpc); end
      vec++; if (mval !== 32'd8) begin err++; $display("FAIL mm_val got %0d exp 8", mval); end
      vec++; if (count !== 7'd1) begin err++; $display("FAIL mm_count got %0d exp 1", count); end
      commit(32'h4, 5'd2, 32'd7);
      commit(32'h8, 5'd3, 32'd12);
      step(5);
      vec++; if ({fail, pass, count, mpc, mval} !== {1'b1, 1'b0, 7'd1, 32'h4, 32'd8}) begin err++;
         $display("FAIL mm_sticky got f%b p%b c%0d %h/%h exp f1 p0 c1 4/8", fail, pass, count, mpc, mval); end
   endtask

   task automatic test_x0();
      do_reset();
      load(6'd0, 32'h0, 5'd0, 32'd0);
      start(7'd1);
      commit(32'h0, 5'd0, 32'hDEADBEEF);
      vec++; if ({pass, fail, count} !== {1'b1, 1'b0, 7'd1}) begin err++;
         $display("FAIL x0_pass got p%b f%b c%0d exp p1 f0 c1", pass, fail, count); end
      // x0 tolerance must not extend to a wrong destination register.
      do_reset();
      start(7'd1);
      commit(32'h0, 5'd4, 32'd0);
      vec++; if ({fail, mpc} !== {1'b1, 32'h0}) begin err++;
         $display("FAIL x0_rd_mismatch got f%b pc %h exp f1 pc 0", fail, mpc); end
   endtask

   task automatic test_timeout();
      do_reset();
      load_basic();
      start(7'd2);
      commit(32'h0, 5'd1, 32'd5);
      step(99);
      vec++; if ({running, fail} !== 2'b10) begin err++;
         $display("FAIL to_99 got r%b f%b exp r1 f0", running, fail); end
      step();
      vec++; if ({fail, timeout, pass, count, mpc, mval} !== {1'b1, 1'b1, 1'b0, 7'd1, 64'h0}) begin err++;
         $display("FAIL to_100 got f%b t%b p%b c%0d %h/%h exp f1 t1 p0 c1 0/0",
                  fail, timeout, pass, count, mpc, mval); end
      // Disabled cycles do not count toward the timeout.
      do_reset();
      start(7'd2);
      commit(32'h0, 5'd1, 32'd5);
      step(50);
      en = 1'b0;
      step(10);
      en = 1'b1;
      step(49);
      vec++; if ({running, fail} !== 2'b10) begin err++;
         $display("FAIL to_slip_early got r%b f%b exp r1 f0", running, fail); end
      step();
      vec++; if ({fail, timeout} !== 2'b11) begin err++;
         $display("FAIL to_slip got f%b t%b exp f1 t1", fail, timeout); end
      // A commit on the expiring cycle is processed instead.
      do_reset();
      start(7'd3);
      commit(32'h0, 5'd1, 32'd5);
      step(99);
      commit(32'h4, 5'd2, 32'd7);
      vec++; if ({running, fail, count} !== {1'b1, 1'b0, 7'd2}) begin err++;
         $display("FAIL to_commit_wins got r%b f%b c%0d exp r1 f0 c2", running, fail, count); end
   endtask

   task automatic test_reset_midrun();
      do_reset();
      start(7'd3);
      commit(32'h0, 5'd1, 32'd5);
      rst = 1'b1;
      step();
      vec++; if ({running, done, pass, fail, timeout, count} !== '0) begin err++;
         $display("FAIL midrst got r%b d%b p%b f%b t%b c%0d exp all 0",
                  running, done, pass, fail, timeout, count); end
      rst = 1'b0;
      en = 1'b0;
      step();
      start(7'd3);
      commit(32'h0, 5'd1, 32'd5);
      commit(32'h4, 5'd2, 32'd7);
      commit(32'h8, 5'd3, 32'd12);
      vec++; if ({pass, count} !== {1'b1, 7'd3}) begin err++;
         $display("FAIL rerun got p%b c%0d exp p1 c3", pass, count); end
   endtask

   task automatic test_length_and_writes();
      do_reset();
      tlen = 7'd0; en = 1'b1;
      step(20);
      vec++; if (running !== 1'b0) begin err++; $display("FAIL len0 got r%b exp 0", running); end
      tlen = 7'd65;
      step(3);
      vec++; if (running !== 1'b0) begin err++; $display("FAIL len65 got r%b exp 0", running); end
      tlen = 7'd64;
      step();
      vec++; if (running !== 1'b1) begin err++; $display("FAIL len64 got r%b exp 1", running); end
      do_reset();
      start(7'd3);
      load(6'd1, 32'h4, 5'd2, 32'd99);
      commit(32'h0, 5'd1, 32'd5);
      commit(32'h4, 5'd2, 32'd7);
      commit(32'h8, 5'd3, 32'd12);
      vec++; if ({pass, fail, count} !== {1'b1, 1'b0, 7'd3}) begin err++;
         $display("FAIL run_write got p%b f%b c%0d exp p1 f0 c3", pass, fail, count); end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_mismatch();
      test_x0();
      test_timeout();
      test_reset_midrun();
      test_length_and_writes();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
